// File: rtl/lcd_receiver.sv
// lcd_receiver: passive HD44780 bus listener that mirrors a 2x16 character display.
//
// Watches the LCD bus driven by an external controller, decodes each write on the
// falling edge of LCD_EN and keeps a 32-byte DDRAM mirror plus cursor, entry mode and
// display-on state. It also emulates the busy period that a real panel would impose.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   LCD_ON/RS/EN/RW/DATA  HD44780 bus being observed (asynchronous to clk)
//   rd_addr, rd_char      mirror read port: index 0-15 is line 1, 16-31 is line 2;
//                         rd_char is registered, so it lags rd_addr by one cycle
//   cursor                current DDRAM index
//   busy                  emulated busy flag
//   display_on            display-control D bit
//   char_valid, cmd_valid one-cycle pulses on each accepted data write / command
//   overrun, bad_addr     sticky error flags, cleared only by reset
module lcd_receiver #(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       LCD_ON,
   input  logic       LCD_RS,
   input  logic       LCD_EN,
   input  logic       LCD_RW,
   input  logic [7:0] LCD_DATA,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [4:0] cursor,
   output logic       busy,
   output logic       display_on,
   output logic       char_valid,
   output logic       cmd_valid,
   output logic       overrun,
   output logic       bad_addr
);

   localparam int MaxCycles = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CntW      = $clog2(MaxCycles + 1);

   // The counter is loaded on entry to EXEC and busy ends once it has run down to zero,
   // so loading N-1 yields exactly N busy cycles.
   localparam logic [CntW-1:0] BusyLoad  = CntW'(BUSY_CYCLES - 1);
   localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYCLES - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StFill = 2'd2;
   localparam logic [1:0] StWait = 2'd3;

   localparam logic [7:0] Blank = 8'h20;

   // LCD_EN synchroniser and edge history
   logic en_meta_q, en_meta_d;
   logic en_sync_q, en_sync_d;
   logic en_prev_q, en_prev_d;

   // Transaction captured on the detection cycle
   logic       txn_valid_q, txn_valid_d;
   logic       txn_rs_q, txn_rs_d;
   logic [7:0] txn_data_q, txn_data_d;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_dec;
   logic [4:0]      fill_q, fill_d;
   logic            is_clear_q, is_clear_d;

   logic [4:0] cursor_q, cursor_d;
   logic       id_q, id_d;
   logic       display_on_q, display_on_d;
   logic       char_valid_q, char_valid_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic       overrun_q, overrun_d;
   logic       bad_addr_q, bad_addr_d;
   logic [7:0] rd_char_q, rd_char_d;
   logic [7:0] ddram_q [32];
   logic [7:0] ddram_d [32];

   always_comb begin
      en_meta_d = LCD_EN;
      en_sync_d = en_meta_q;
      en_prev_d = en_sync_q;

      // Reads and powered-off cycles are filtered here so they never reach the FSM.
      txn_valid_d = en_prev_q & ~en_sync_q & LCD_ON & ~LCD_RW;
      txn_rs_d    = LCD_RS;
      txn_data_d  = LCD_DATA;

      cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);

      state_d      = state_q;
      cnt_d        = cnt_q;
      fill_d       = fill_q;
      is_clear_d   = is_clear_q;
      cursor_d     = cursor_q;
      id_d         = id_q;
      display_on_d = display_on_q;
      char_valid_d = 1'b0;
      cmd_valid_d  = 1'b0;
      overrun_d    = overrun_q;
      bad_addr_d   = bad_addr_q;
      ddram_d      = ddram_q;
      rd_char_d    = ddram_q[rd_addr];

      if (txn_valid_q && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (txn_valid_q) begin
               state_d    = StExec;
               cnt_d      = BusyLoad;
               is_clear_d = 1'b0;
               if (txn_rs_q) begin
                  ddram_d[cursor_q] = txn_data_q;
                  // 5-bit wrap gives 15<->16 and 31<->0 for free
                  cursor_d     = id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
                  char_valid_d = 1'b1;
               end else begin
                  cmd_valid_d = 1'b1;
                  unique casez (txn_data_q)
                     8'b1???????: begin
                        if (txn_data_q[6:4] == 3'b000) begin
                           cursor_d = {1'b0, txn_data_q[3:0]};
                        end else if (txn_data_q[6:4] == 3'b100) begin
                           cursor_d = {1'b1, txn_data_q[3:0]};
                        end else begin
                           bad_addr_d = 1'b1;
                        end
                     end
                     // function set, shift, CGRAM address: acknowledged, no mirror state
                     8'b01??????, 8'b001?????, 8'b0001????: ;
                     8'b00001???: display_on_d = txn_data_q[2];
                     8'b000001??: id_d = txn_data_q[1];
                     8'b0000001?: begin
                        cursor_d = 5'd0;
                        cnt_d    = ClearLoad;
                     end
                     8'b00000001: begin
                        cursor_d   = 5'd0;
                        id_d       = 1'b1;
                        is_clear_d = 1'b1;
                        cnt_d      = ClearLoad;
                     end
                     default: ;
                  endcase
               end
            end
         end

         StExec: begin
            cnt_d  = cnt_dec;
            fill_d = 5'd0;
            if (is_clear_q) begin
               state_d = StFill;
            end else if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               state_d = StWait;
            end
         end

         // One byte per cycle; these cycles are part of the clear busy time.
         StFill: begin
            ddram_d[fill_q] = Blank;
            fill_d          = fill_q + 5'd1;
            cnt_d           = cnt_dec;
            if (fill_q == 5'd31) begin
               state_d = StWait;
            end
         end

         StWait: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_dec;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_meta_q    <= 1'b0;
         en_sync_q    <= 1'b0;
         en_prev_q    <= 1'b0;
         txn_valid_q  <= 1'b0;
         txn_rs_q     <= 1'b0;
         txn_data_q   <= 8'h00;
         state_q      <= StIdle;
         cnt_q        <= '0;
         fill_q       <= 5'd0;
         is_clear_q   <= 1'b0;
         cursor_q     <= 5'd0;
         id_q         <= 1'b1;
         display_on_q <= 1'b0;
         char_valid_q <= 1'b0;
         cmd_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         bad_addr_q   <= 1'b0;
         rd_char_q    <= Blank;
         for (int i = 0; i < 32; i++) begin
            ddram_q[i] <= Blank;
         end
      end else begin
         en_meta_q    <= en_meta_d;
         en_sync_q    <= en_sync_d;
         en_prev_q    <= en_prev_d;
         txn_valid_q  <= txn_valid_d;
         txn_rs_q     <= txn_rs_d;
         txn_data_q   <= txn_data_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fill_q       <= fill_d;
         is_clear_q   <= is_clear_d;
         cursor_q     <= cursor_d;
         id_q         <= id_d;
         display_on_q <= display_on_d;
         char_valid_q <= char_valid_d;
         cmd_valid_q  <= cmd_valid_d;
         overrun_q    <= overrun_d;
         bad_addr_q   <= bad_addr_d;
         rd_char_q    <= rd_char_d;
         ddram_q      <= ddram_d;
      end
   end

   assign rd_char    = rd_char_q;
   assign cursor     = cursor_q;
   assign busy       = (state_q != StIdle);
   assign display_on = display_on_q;
   assign char_valid = char_valid_q;
   assign cmd_valid  = cmd_valid_q;
   assign overrun    = overrun_q;
   assign bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_lcd_receiver.sv
// Testbench for lcd_receiver: directed vector table, hand-written multi-cycle sequences
// (latency, busy length, clear, overrun, reset mid-fill) and a randomized phase checked
// against a behavioural model of the mirrored display.
module tb_lcd_receiver;

   // Short busy times keep the run small; the relationships checked do not depend on them.
   localparam int BusyCyc  = 150;
   localparam int ClearCyc = 400;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       LCD_ON = 1'b1, LCD_RS = 1'b0, LCD_EN = 1'b0, LCD_RW = 1'b0;
   logic [7:0] LCD_DATA = 8'h00;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_char;
   logic [4:0] cursor;
   logic       busy, display_on, char_valid, cmd_valid, overrun, bad_addr;

   lcd_receiver #(
      .BUSY_CYCLES (BusyCyc),
      .CLEAR_CYCLES(ClearCyc)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .LCD_ON    (LCD_ON),
      .LCD_RS    (LCD_RS),
      .LCD_EN    (LCD_EN),
      .LCD_RW    (LCD_RW),
      .LCD_DATA  (LCD_DATA),
      .rd_addr   (rd_addr),
      .rd_char   (rd_char),
      .cursor    (cursor),
      .busy      (busy),
      .display_on(display_on),
      .char_valid(char_valid),
      .cmd_valid (cmd_valid),
      .overrun   (overrun),
      .bad_addr  (bad_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Pulse counters, sampled away from the active edge
   int   cv_cnt = 0, cmd_cnt = 0, wide_cnt = 0;
   logic cv_prev = 1'b0, cmd_prev = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         cv_prev  = 1'b0;
         cmd_prev = 1'b0;
      end else begin
         if (char_valid) cv_cnt++;
         if (cmd_valid) cmd_cnt++;
         if ((char_valid && cv_prev) || (cmd_valid && cmd_prev)) wide_cnt++;
         cv_prev  = char_valid;
         cmd_prev = cmd_valid;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      LCD_EN = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Drives one bus write; c is the cycle count at the moment LCD_EN drops.
   task automatic txn_start(input logic rs, input logic rw, input logic on,
                            input logic [7:0] d, output int c);
      @(negedge clk);
      LCD_RS   = rs;
      LCD_RW   = rw;
      LCD_ON   = on;
      LCD_DATA = d;
      LCD_EN   = 1'b1;
      repeat (3) @(negedge clk);
      LCD_EN = 1'b0;
      c      = cyc;
   endtask

   task automatic txn(input logic rs, input logic rw, input logic on, input logic [7:0] d);
      int c;
      txn_start(rs, rw, on, d, c);
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < ClearCyc + 100) begin
         @(negedge clk);
         k++;
      end
      check("wait_idle", int'(busy), 0);
   endtask

   task automatic read_char(input int idx, output logic [7:0] ch);
      rd_addr = 5'(idx);
      @(negedge clk);
      ch = rd_char;
   endtask

   task automatic prefill();
      for (int i = 0; i < 32; i++) begin
         txn(1'b1, 1'b0, 1'b1, 8'(8'h40 + i));
         wait_idle();
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_mem [32];
   int         m_cur, m_end, m_cv, m_cmd;
   bit         m_id, m_disp, m_ovr, m_bad;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_cur = 0; m_id = 1; m_disp = 0; m_ovr = 0; m_bad = 0;
      m_cv = 0; m_cmd = 0; m_end = cyc;
   endtask

   // e is the clock count at which the transaction takes effect
   task automatic model_txn(input bit rs, input bit rw, input bit on, input int d, input int e);
      int dur = BusyCyc;
      int a;
      if (rw || !on) return;
      if (e - 1 < m_end) begin
         m_ovr = 1;
         return;
      end
      if (rs) begin
         m_mem[m_cur] = 8'(d);
         m_cur = (m_cur + (m_id ? 1 : 31)) % 32;
         m_cv++;
      end else begin
         m_cmd++;
         if (d >= 128) begin
            a = d - 128;
            if (a < 16) m_cur = a;
            else if (a >= 64 && a < 80) m_cur = 16 + (a - 64);
            else m_bad = 1;
         end else if (d >= 16) begin
         end else if (d >= 8) begin
            m_disp = ((d / 4) % 2) == 1;
         end else if (d >= 4) begin
            m_id = ((d / 2) % 2) == 1;
         end else if (d >= 2) begin
            m_cur = 0; dur = ClearCyc;
         end else if (d == 1) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_cur = 0; m_id = 1; dur = ClearCyc;
         end
      end
      m_end = e + dur;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rs, rw, on;
      logic [7:0] data;
      int         cur;
      bit         disp, bad;
      int         idx;
      logic [7:0] ch;
      int         cv, cmd;
   } vec_t;
   vec_t tbl[$];

   int         c, base_cv, base_cmd, first_busy, first_cv, first_cmd, busy_len;
   logic [7:0] ch;
   logic       rs, rw, on;
   logic [7:0] d;

   initial begin
      tbl.push_back('{1, 0, 1, 8'h41,  1, 0, 0,  0, 8'h41, 1, 0});
      tbl.push_back('{0, 0, 1, 8'h8F, 15, 0, 0,  0, 8'h41, 0, 1});
      tbl.push_back('{1, 0, 1, 8'h5A, 16, 0, 0, 15, 8'h5A, 1, 0});
      tbl.push_back('{0, 0, 1, 8'h80,  0, 0, 0, 15, 8'h5A, 0, 1});
      tbl.push_back('{0, 0, 1, 8'h04,  0, 0, 0,  1, 8'h20, 0, 1});
      tbl.push_back('{1, 0, 1, 8'h33, 31, 0, 0,  0, 8'h33, 1, 0});
      tbl.push_back('{1, 0, 1, 8'h34, 30, 0, 0, 31, 8'h34, 1, 0});
      tbl.push_back('{0, 0, 1, 8'h0C, 30, 1, 0, 30, 8'h20, 0, 1});
      tbl.push_back('{0, 0, 1, 8'h08, 30, 0, 0, 30, 8'h20, 0, 1});
      tbl.push_back('{1, 1, 1, 8'h41, 30, 0, 0, 30, 8'h20, 0, 0});
      tbl.push_back('{1, 0, 0, 8'h77, 30, 0, 0, 30, 8'h20, 0, 0});
      tbl.push_back('{0, 0, 1, 8'hC5, 21, 0, 0, 21, 8'h20, 0, 1});
      tbl.push_back('{0, 0, 1, 8'h06, 21, 0, 0, 21, 8'h20, 0, 1});
      tbl.push_back('{1, 0, 1, 8'h61, 22, 0, 0, 21, 8'h61, 1, 0});
      tbl.push_back('{0, 0, 1, 8'h95, 22, 0, 1, 22, 8'h20, 0, 1});
      tbl.push_back('{0, 0, 1, 8'h02,  0, 0, 1,  0, 8'h33, 0, 1});
      tbl.push_back('{0, 0, 1, 8'h00,  0, 0, 1,  0, 8'h33, 0, 1});

      // Reset state, observed while reset is held and after release
      repeat (2) @(negedge clk);
      check("rst_rd_char", rd_char, 8'h20);
      check("rst_busy", busy, 0);
      do_reset();
      check("rst_cursor", cursor, 0);
      check("rst_display_on", display_on, 0);
      check("rst_flags", {overrun, bad_addr, char_valid, cmd_valid}, 0);

      // First write: pipeline latency and busy length
      base_cv = cv_cnt;
      txn_start(1'b1, 1'b0, 1'b1, 8'h41, c);
      first_busy = -1; first_cv = -1; busy_len = 0;
      for (int k = 1; k <= BusyCyc + 20; k++) begin
         @(negedge clk);
         if (busy && first_busy < 0) first_busy = k;
         if (char_valid && first_cv < 0) first_cv = k;
         if (busy) busy_len++;
      end
      check("busy_rise_edge", first_busy, 4);
      check("char_valid_edge", first_cv, 4);
      check("busy_len_write", busy_len, BusyCyc);
      check("write_cv_count", cv_cnt - base_cv, 1);
      read_char(0, ch);
      check("write_ddram0", ch, 8'h41);
      check("write_cursor", cursor, 1);

      // Directed table from a fresh reset
      do_reset();
      foreach (tbl[i]) begin
         base_cv  = cv_cnt;
         base_cmd = cmd_cnt;
         txn(tbl[i].rs, tbl[i].rw, tbl[i].on, tbl[i].data);
         wait_idle();
         check($sformatf("tbl%0d_cursor", i), cursor, tbl[i].cur);
         check($sformatf("tbl%0d_display_on", i), display_on, tbl[i].disp);
         check($sformatf("tbl%0d_bad_addr", i), bad_addr, tbl[i].bad);
         check($sformatf("tbl%0d_overrun", i), overrun, 0);
         check($sformatf("tbl%0d_char_valid", i), cv_cnt - base_cv, tbl[i].cv);
         check($sformatf("tbl%0d_cmd_valid", i), cmd_cnt - base_cmd, tbl[i].cmd);
         read_char(tbl[i].idx, ch);
         check($sformatf("tbl%0d_ddram", i), ch, tbl[i].ch);
      end

      // Overrun: second write ~100 cycles into the first one's busy period
      base_cv = cv_cnt;
      txn(1'b1, 1'b0, 1'b1, 8'h41);
      repeat (92) @(negedge clk);
      check("ovr_still_busy", busy, 1);
      txn(1'b1, 1'b0, 1'b1, 8'h42);
      wait_idle();
      check("ovr_flag", overrun, 1);
      check("ovr_cursor", cursor, 1);
      check("ovr_cv_count", cv_cnt - base_cv, 1);
      read_char(1, ch);
      check("ovr_ddram1", ch, 8'h20);
      read_char(0, ch);
      check("ovr_ddram0", ch, 8'h41);

      // Clear display after filling, with I/D=0 beforehand
      do_reset();
      prefill();
      check("prefill_cursor", cursor, 0);
      txn(1'b0, 1'b0, 1'b1, 8'h04);
      wait_idle();
      base_cmd = cmd_cnt;
      txn_start(1'b0, 1'b0, 1'b1, 8'h01, c);
      busy_len = 0; first_cmd = -1;
      for (int k = 1; k <= ClearCyc + 20; k++) begin
         @(negedge clk);
         if (busy) busy_len++;
         if (cmd_valid && first_cmd < 0) first_cmd = k;
      end
      check("busy_len_clear", busy_len, ClearCyc);
      check("clear_cmd_edge", first_cmd, 4);
      check("clear_cmd_count", cmd_cnt - base_cmd, 1);
      check("clear_cursor", cursor, 0);
      for (int i = 0; i < 32; i++) begin
         read_char(i, ch);
         check($sformatf("clear_ddram%0d", i), ch, 8'h20);
      end
      txn(1'b1, 1'b0, 1'b1, 8'h55);
      wait_idle();
      check("clear_sets_increment", cursor, 1);

      // Reset at fill cycle 10 of a clear
      do_reset();
      prefill();
      txn_start(1'b0, 1'b0, 1'b1, 8'h01, c);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 12) rd_addr = 5'd20;
         if (k == 13) begin
            check("fill_hi_untouched", rd_char, 8'h54);
            rd_addr = 5'd7;
         end
         if (k == 14) check("fill_lo_cleared", rd_char, 8'h20);
      end
      reset = 1'b1;
      #1;
      check("midfill_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midfill_cursor", cursor, 0);
      base_cmd = 0;
      for (int i = 0; i < 32; i++) begin
         read_char(i, ch);
         if (ch != 8'h20) base_cmd++;
      end
      check("midfill_nonblank_bytes", base_cmd, 0);
      base_cv = cv_cnt;
      txn(1'b1, 1'b0, 1'b1, 8'h7E);
      check("midfill_idle_accepts", cv_cnt - base_cv, 1);
      check("midfill_no_overrun", overrun, 0);
      wait_idle();

      // Randomized traffic against the model
      do_reset();
      model_reset();
      base_cv  = cv_cnt;
      base_cmd = cmd_cnt;
      for (int t = 0; t < 60; t++) begin
         rs = 1'($urandom_range(0, 1));
         rw = ($urandom_range(0, 7) == 0);
         on = ($urandom_range(0, 7) != 0);
         d  = 8'($urandom);
         if (!rs) begin
            case ($urandom_range(0, 3))
               0: d = d & 8'h0F;
               1: d = 8'h80 | (d & 8'h4F);
               default: ;
            endcase
         end
         txn_start(rs, rw, on, d, c);
         model_txn(rs, rw, on, int'(d), c + 4);
         repeat (5) @(negedge clk);
         check($sformatf("rnd%0d_cursor", t), cursor, m_cur);
         check($sformatf("rnd%0d_display_on", t), display_on, m_disp);
         check($sformatf("rnd%0d_overrun", t), overrun, m_ovr);
         check($sformatf("rnd%0d_bad_addr", t), bad_addr, m_bad);
         repeat ($urandom_range(0, 200)) @(negedge clk);
      end
      wait_idle();
      check("rnd_cv_count", cv_cnt - base_cv, m_cv);
      check("rnd_cmd_count", cmd_cnt - base_cmd, m_cmd);
      for (int i = 0; i < 32; i++) begin
         read_char(i, ch);
         check($sformatf("rnd_ddram%0d", i), ch, m_mem[i]);
      end
      check("pulse_width", wide_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
